// File: rtl/uart_boot_loader_ctrl_pkg.sv
// Shared definitions for the UART boot loader: state encoding, word width, default end marker.
// Optional feature macro used across this slice: LOADER_TIMEOUT_EN.
package uart_boot_loader_ctrl_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  localparam word_t END_MARKER_DEFAULT = 32'd3027;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/uart_boot_loader_ctrl_byte_packer.sv
// Packs received bytes MSB-first into 32-bit words; with LOADER_TIMEOUT_EN an idle
// partial word is discarded after TIMEOUT_CYC cycles.
module byte_packer
  import uart_boot_loader_ctrl_pkg::*;
`ifdef LOADER_TIMEOUT_EN
#(
  parameter int unsigned TIMEOUT_CYC = 30000
)
`endif
(
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       restart,
  output logic       word_valid,
  output word_t      word,
  output logic       timeout
);

  logic [1:0]  idx;
  logic [23:0] sh;

  // A restarting byte is always byte 0 of a fresh word, whatever idx holds.
  assign word_valid = rx_valid && !restart && (idx == 2'd3);
  assign word       = {sh, rx_data};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= 2'd0;
    end else if (rx_valid) begin
      idx <= restart ? 2'd1 : idx + 2'd1;
    end else if (timeout) begin
      idx <= 2'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rx_valid) begin
      sh <= {sh[15:0], rx_data};
    end
  end

`ifdef LOADER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] idle_cnt;

  assign timeout = !rx_valid && (idx != 2'd0) && (idle_cnt == CNT_W'(TIMEOUT_CYC));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt <= '0;
    end else if (rx_valid || timeout) begin
      idle_cnt <= '0;
    end else if (idx != 2'd0) begin
      idle_cnt <= idle_cnt + CNT_W'(1);
    end
  end
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: rtl/uart_boot_loader_ctrl.sv
// Boot loader sequencer: UART bytes -> program-memory word writes, releases cpu_hold on END_MARKER.
// Optional inter-byte timeout enabled by defining LOADER_TIMEOUT_EN.
module uart_boot_loader_ctrl
  import uart_boot_loader_ctrl_pkg::*;
#(
  parameter int          ADDR_W     = 12,
  parameter int unsigned BASE_ADDR  = 0,
  parameter word_t       END_MARKER = END_MARKER_DEFAULT
`ifdef LOADER_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYC = 30000
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output word_t             mem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic [ADDR_W:0]   word_cnt,
  output logic              ovf_err,
  output logic              timeout_err
);

  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

  logic [1:0] state;
  logic       marker_pend;
  logic       word_valid;
  word_t      word;
  logic       timeout;
  logic       is_marker;

  assign is_marker = (word == END_MARKER);
  assign mem_we    = mem_req;

  byte_packer
`ifdef LOADER_TIMEOUT_EN
  #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  )
`endif
  u_packer (
    .clk       (clk),
    .rst       (rst),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .restart   (state == ST_DONE),
    .word_valid(word_valid),
    .word      (word),
    .timeout   (timeout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      cpu_hold    <= 1'b1;
      mem_req     <= 1'b0;
      mem_addr    <= BASE;
      mem_wdata   <= '0;
      load_done   <= 1'b0;
      word_cnt    <= '0;
      ovf_err     <= 1'b0;
      timeout_err <= 1'b0;
      marker_pend <= 1'b0;
    end else begin
      load_done <= 1'b0;
      if (timeout) begin
        timeout_err <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (rx_valid) begin
            state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (word_valid) begin
            if (is_marker) begin
              state     <= ST_DONE;
              cpu_hold  <= 1'b0;
              load_done <= 1'b1;
            end else if (word_cnt == FULL_CNT) begin
              ovf_err <= 1'b1;
            end else begin
              mem_wdata <= word;
              mem_req   <= 1'b1;
              state     <= ST_WRITE;
            end
          end
        end
        ST_WRITE: begin
          // Only one word can be in flight; a marker is remembered, anything else is lost.
          if (word_valid) begin
            if (is_marker) begin
              marker_pend <= 1'b1;
            end else begin
              ovf_err <= 1'b1;
            end
          end
          if (mem_gnt) begin
            mem_req  <= 1'b0;
            mem_addr <= mem_addr + ADDR_W'(1);
            word_cnt <= word_cnt + (ADDR_W+1)'(1);
            if (marker_pend || (word_valid && is_marker)) begin
              state       <= ST_DONE;
              cpu_hold    <= 1'b0;
              load_done   <= 1'b1;
              marker_pend <= 1'b0;
            end else begin
              state <= ST_LOAD;
            end
          end
        end
        ST_DONE: begin
          if (rx_valid) begin
            state       <= ST_LOAD;
            cpu_hold    <= 1'b1;
            mem_addr    <= BASE;
            word_cnt    <= '0;
            ovf_err     <= 1'b0;
            timeout_err <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_boot_loader_ctrl.sv
// Directed bench for uart_boot_loader_ctrl (default parameters; LOADER_TIMEOUT_EN selects the timeout case).
module tb_uart_boot_loader_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        mem_req;
  logic        mem_gnt;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        load_done;
  logic [12:0] word_cnt;
  logic        ovf_err;
  logic        timeout_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [11:0] wa_q[$];
  logic [31:0] wd_q[$];

  uart_boot_loader_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .mem_req    (mem_req),
    .mem_gnt    (mem_gnt),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .word_cnt   (word_cnt),
    .ovf_err    (ovf_err),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Record every committed write (handshake seen at the active edge).
  always @(posedge clk) begin
    if (!rst && mem_req && mem_gnt) begin
      wa_q.push_back(mem_addr);
      wd_q.push_back(mem_wdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".cpu_hold"},    32'(cpu_hold),    32'd1);
    check({tag, ".mem_req"},     32'(mem_req),     32'd0);
    check({tag, ".mem_we"},      32'(mem_we),      32'd0);
    check({tag, ".mem_addr"},    32'(mem_addr),    32'd0);
    check({tag, ".mem_wdata"},   mem_wdata,        32'd0);
    check({tag, ".load_done"},   32'(load_done),   32'd0);
    check({tag, ".word_cnt"},    32'(word_cnt),    32'd0);
    check({tag, ".ovf_err"},     32'(ovf_err),     32'd0);
    check({tag, ".timeout_err"}, 32'(timeout_err), 32'd0);
  endtask

  // Called at a negedge; returns at the negedge after the capturing edge.
  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  task automatic check_write(input string tag, input int idx, input logic [11:0] a, input logic [31:0] d);
    check({tag, ".addr"}, (wa_q.size() > idx) ? 32'(wa_q[idx]) : 32'hxxxx_xxxx, 32'(a));
    check({tag, ".data"}, (wd_q.size() > idx) ? wd_q[idx] : 32'hxxxx_xxxx, d);
  endtask

  task automatic clear_log();
    wa_q.delete();
    wd_q.delete();
  endtask

  initial begin
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    mem_gnt  = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    rst = 1'b0;
    @(negedge clk);

    // Three words then the marker, grant always high.
    mem_gnt = 1'b1;
    send_word(32'd238);
    send_word(32'd74);
    send_word(32'd95);
    send_word(32'd3027);
    check("a.load_done", 32'(load_done), 32'd1);
    check("a.cpu_hold",  32'(cpu_hold),  32'd0);
    check("a.word_cnt",  32'(word_cnt),  32'd3);
    check("a.nwrites",   32'(wa_q.size()), 32'd3);
    check_write("a.w0", 0, 12'd0, 32'd238);
    check_write("a.w1", 1, 12'd1, 32'd74);
    check_write("a.w2", 2, 12'd2, 32'd95);
    @(negedge clk);
    check("a.load_done_pulse", 32'(load_done), 32'd0);
    check("a.cpu_hold_stays",  32'(cpu_hold),  32'd0);

    // Restart from DONE: 42 then marker.
    clear_log();
    send_byte(8'h00);
    check("d.cpu_hold_rise", 32'(cpu_hold), 32'd1);
    check("d.word_cnt_clr",  32'(word_cnt), 32'd0);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'd42);
    send_word(32'd3027);
    check("d.load_done", 32'(load_done), 32'd1);
    check("d.word_cnt",  32'(word_cnt),  32'd1);
    check("d.nwrites",   32'(wa_q.size()), 32'd1);
    check_write("d.w0", 0, 12'd0, 32'd42);

    // Grant held low for 20 cycles after word 238.
    clear_log();
    mem_gnt = 1'b0;
    send_word(32'd238);
    for (int i = 0; i < 20; i++) begin
      check("b.mem_req",   32'(mem_req),  32'd1);
      check("b.mem_addr",  32'(mem_addr), 32'd0);
      check("b.mem_wdata", mem_wdata,     32'd238);
      @(negedge clk);
    end
    check("b.nwrites_stall", 32'(wa_q.size()), 32'd0);
    mem_gnt = 1'b1;
    @(negedge clk);
    check("b.nwrites",  32'(wa_q.size()), 32'd1);
    check_write("b.w0", 0, 12'd0, 32'd238);
    check("b.mem_req_drop", 32'(mem_req),  32'd0);
    check("b.word_cnt",     32'(word_cnt), 32'd1);
    check("b.mem_addr_inc", 32'(mem_addr), 32'd1);
    send_word(32'd3027);
    check("b.load_done", 32'(load_done), 32'd1);

    // Overrun while waiting for grant, then marker pending until grant.
    clear_log();
    mem_gnt = 1'b0;
    send_word(32'h1122_3344);
    check("c.ovf_clr", 32'(ovf_err), 32'd0);
    send_word(32'h5566_7788);
    check("c.ovf_err",   32'(ovf_err),  32'd1);
    check("c.mem_wdata", mem_wdata,     32'h1122_3344);
    check("c.mem_addr",  32'(mem_addr), 32'd0);
    send_word(32'd3027);
    check("c.pend_no_done", 32'(load_done), 32'd0);
    check("c.pend_hold",    32'(cpu_hold),  32'd1);
    mem_gnt = 1'b1;
    @(negedge clk);
    check("c.load_done", 32'(load_done), 32'd1);
    check("c.cpu_hold",  32'(cpu_hold),  32'd0);
    check("c.word_cnt",  32'(word_cnt),  32'd1);
    check("c.ovf_sticky", 32'(ovf_err),  32'd1);
    check("c.nwrites",   32'(wa_q.size()), 32'd1);
    check_write("c.w0", 0, 12'd0, 32'h1122_3344);
    @(negedge clk);
    check("c.load_done_pulse", 32'(load_done), 32'd0);

    // Partial word across an idle gap.
    clear_log();
    send_byte(8'h00);
    check("t.ovf_cleared", 32'(ovf_err), 32'd0);
    send_byte(8'h00);
`ifdef LOADER_TIMEOUT_EN
    repeat (30005) @(negedge clk);
    check("t.timeout_err", 32'(timeout_err), 32'd1);
    send_word(32'h0000_00EE);
    @(negedge clk);
    check("t.nwrites", 32'(wa_q.size()), 32'd1);
    check_write("t.w0", 0, 12'd0, 32'd238);
`else
    repeat (50) @(negedge clk);
    check("t.timeout_err", 32'(timeout_err), 32'd0);
    send_byte(8'h12);
    send_byte(8'h34);
    @(negedge clk);
    check("t.nwrites", 32'(wa_q.size()), 32'd1);
    check_write("t.w0", 0, 12'd0, 32'h0000_1234);
`endif

    // Reset while a write request is outstanding.
    clear_log();
    mem_gnt = 1'b0;
    send_word(32'h0000_0055);
    check("r.mem_req_before", 32'(mem_req), 32'd1);
    rst = 1'b1;
    #1;
    check_reset_vals("r.async");
    mem_gnt = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("r.nwrites", 32'(wa_q.size()), 32'd0);
    check("r.mem_req_after", 32'(mem_req), 32'd0);
    send_word(32'd7);
    @(negedge clk);
    check("r.nwrites_post", 32'(wa_q.size()), 32'd1);
    check_write("r.w0", 0, 12'd0, 32'd7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_boot_loader_ctrl.md
# uart_boot_loader_ctrl

Sequencer that turns the UART boot byte stream into program-memory writes and holds the CPU until the image is in place. It takes received bytes from the UART RX byte receiver and packs each group of four into a 32-bit word, most significant byte first. It owns the program-memory write port through a request/grant handshake and writes words to consecutive word addresses. When the end-marker word arrives it releases the CPU. It sits between the UART receiver, the ROM/RAM write port and the core's hold input inside the top level.

## Interface
- ADDR_W, 12: word-address width of program memory.
- BASE_ADDR, 0: first word address written.
- END_MARKER, 32'd3027: terminating word; never written to memory.
- TIMEOUT_CYC, 30000: inter-byte idle limit in clk cycles (only with the macro).
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- rx_valid  in  1  one-cycle pulse: rx_data holds a received byte.
- rx_data  in  8  received byte.
- mem_req  out  1  write request; held until granted.
- mem_gnt  in  1  grant; transfer occurs on a clk edge where mem_req && mem_gnt.
- mem_we  out  1  equals mem_req.
- mem_addr  out  ADDR_W  word address; stable while mem_req is high.
- mem_wdata  out  32  word data; stable while mem_req is high.
- cpu_hold  out  1  holds the core in reset/stall.
- load_done  out  1  one-cycle pulse on entry to DONE.
- word_cnt  out  ADDR_W+1  number of words written in the current load.
- ovf_err  out  1  sticky: word dropped (pending overrun or address space full).
- timeout_err  out  1  sticky: partial word discarded by timeout (tied 0 without the macro).

## Operation
- States: IDLE, LOAD, WRITE, DONE. Reset puts the block in IDLE with these values:
  - cpu_hold=1
  - mem_req=0, mem_addr=BASE_ADDR, mem_wdata=0
  - load_done=0, word_cnt=0, ovf_err=0, timeout_err=0
  - byte index=0
- Byte packing: shift register sh <= {sh[23:0], rx_data} on each rx_valid. A 2-bit byte index counts 0..3 and wraps.
- Word completion is the rx_valid with index==3. The completed word is {sh[23:0], rx_data}.
- IDLE: the first rx_valid moves the block to LOAD.
- LOAD: on word completion:
  - If the word is END_MARKER: go to DONE.
  - Else, if word_cnt == 2^ADDR_W: drop the word, set ovf_err, stay in LOAD.
  - Otherwise: latch mem_wdata, go to WRITE.
- WRITE: mem_req=1. On grant: mem_addr+1 (wraps mod 2^ADDR_W), word_cnt+1, then go to LOAD. If a marker is pending, go to DONE instead.
- Byte reception continues during WRITE. A word completing during WRITE is handled as follows:
  - A non-marker word is dropped and sets ovf_err.
  - END_MARKER sets marker-pending.
- DONE: cpu_hold=0, load_done pulses for one cycle.
- A new rx_valid in DONE restarts the load:
  - cpu_hold=1 on the next cycle.
  - mem_addr=BASE_ADDR, word_cnt=0, ovf_err and timeout_err cleared.
  - That byte counts as byte 0; the block enters LOAD.
- Reset mid-load aborts immediately: an in-flight mem_req drops and no partial word is written.

## Timing
- A completing rx_valid in cycle N gives mem_req=1 in cycle N+1. With mem_gnt already high, the write commits at the end of cycle N+1.
- END_MARKER completing in cycle N: cpu_hold=0 and load_done=1 in N+1.
- Marker-pending path: DONE is entered the cycle after the grant edge.
- rx_valid and mem_gnt in the same cycle are both honored.
- mem_req is never withdrawn before grant, except by reset.

## Configuration
- LOADER_TIMEOUT_EN defined:
  - A counter clears on every rx_valid and increments while the byte index != 0.
  - When it reaches TIMEOUT_CYC: byte index resets to 0, the partial word is discarded and timeout_err is set. The state is unchanged; a pending write still completes.
- LOADER_TIMEOUT_EN undefined: no counter is built, timeout_err=0, and a partial word waits indefinitely.

## Structure
- Shared package (defines include): state encoding, the 32-bit word width and the END_MARKER default.
- Sub-module byte_packer: shift register, byte index and the optional timeout. It outputs a word_valid pulse and the 32-bit word.
- The controller FSM stays in uart_boot_loader_ctrl.

## Test plan
- Three words 238, 74, 95 then 3027 with mem_gnt=1:
  - writes at addresses 0, 1, 2 with data 238, 74, 95
  - then load_done pulse, cpu_hold=0, word_cnt=3
- mem_gnt held low 20 cycles after word 238: mem_req, mem_addr=0 and mem_wdata=238 stay stable, and the write commits on the first grant edge.
- Second word completes while mem_gnt is still low: ovf_err=1, the second word is never written, and the first commits at address 0.
- After DONE, resend 42 then 3027: cpu_hold rises the cycle after the first byte, 42 is written at address 0, word_cnt=1 at the second load_done.
- With LOADER_TIMEOUT_EN: send 2 bytes, idle for TIMEOUT_CYC cycles, then 4 bytes of 0x0000_00EE:
  - timeout_err=1
  - the write carries 238 (not misaligned data)
- Assert rst while mem_req=1: mem_req=0 and cpu_hold=1 immediately, and all outputs take their reset values.
